// File: rtl/pixel_fb_writer.sv
`default_nettype none
// ============================================================================
// Module   : pixel_fb_writer
// Purpose  : Captures the drawer's (x, y, colour, plot) pixel stream, turns
//            each in-range coordinate into a linear framebuffer address
//            (y * X_SCREEN_PIXELS + x) and queues {address, colour} in a small
//            FIFO. The FIFO drains to the video-memory write port under a
//            valid/ready handshake, so a drawer with no backpressure can feed
//            a memory port that may stall.
// Ports    : iClock      - system clock, all state changes on posedge
//            iResetn     - synchronous active-low reset
//            iX/iY       - pixel coordinate from the drawer
//            iColour     - pixel colour from the drawer
//            iPlot       - pixel valid, at most one pixel per cycle
//            iMemReady   - memory port accepts the current write
//            oMemAddr    - head entry address (0 while empty)
//            oMemData    - head entry colour  (0 while empty)
//            oMemWrEn    - write valid (FIFO not empty)
//            oFull       - FIFO holds FIFO_DEPTH entries
//            oIdle       - FIFO empty
//            oOverflow   - sticky flag: an in-range pixel was lost (full)
//            oDropCount  - saturating count of out-of-range pixels
// Options  : PIXEL_FB_COLOUR_KEY_EN - when defined, in-range pixels whose
//            colour equals TRANSPARENT_COLOUR are discarded silently.
// Revision : 1.0 - initial release
// ============================================================================

module pixel_fb_writer #(
    parameter logic [7:0] X_SCREEN_PIXELS    = 8'd160,
    parameter logic [6:0] Y_SCREEN_PIXELS    = 7'd120,
    parameter int         FIFO_DEPTH         = 8,
    parameter int         ADDR_WIDTH         = 15,
    parameter logic [2:0] TRANSPARENT_COLOUR = 3'd0
) (
    input  logic                  iClock,
    input  logic                  iResetn,
    input  logic [7:0]            iX,
    input  logic [6:0]            iY,
    input  logic [2:0]            iColour,
    input  logic                  iPlot,
    input  logic                  iMemReady,
    output logic [ADDR_WIDTH-1:0] oMemAddr,
    output logic [2:0]            oMemData,
    output logic                  oMemWrEn,
    output logic                  oFull,
    output logic                  oIdle,
    output logic                  oOverflow,
    output logic [7:0]            oDropCount
);

    localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int ENTRY_W = ADDR_WIDTH + 3;

    localparam logic [PTR_W:0] c_depth     = FIFO_DEPTH[PTR_W:0];
    localparam logic [PTR_W:0] c_count_one = {{PTR_W{1'b0}}, 1'b1};
    localparam logic [7:0]     c_drop_max  = 8'hFF;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [ENTRY_W-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W:0]     r_count;
    logic               r_overflow;
    logic [7:0]         r_drop_count;

    // ------------------------------------------------------------------
    // Input qualification
    // ------------------------------------------------------------------
    logic                  w_in_range;
    logic                  w_key_hit;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_drop;
    logic                  w_lost;
    logic [ADDR_WIDTH-1:0] w_addr;

    assign w_in_range = (iX < X_SCREEN_PIXELS) && (iY < Y_SCREEN_PIXELS);

`ifdef PIXEL_FB_COLOUR_KEY_EN
    assign w_key_hit = (iColour == TRANSPARENT_COLOUR);
`else
    // Keying disabled: the compare is masked off so every colour is queued.
    assign w_key_hit = 1'b0 & (iColour == TRANSPARENT_COLOUR);
`endif

    assign w_full  = (r_count == c_depth);
    assign w_empty = (r_count == '0);

    // Range check wins over the full check, so an out-of-range pixel that
    // arrives while full counts as a drop, never as an overflow.
    assign w_drop = iPlot && !w_in_range;
    assign w_lost = iPlot &&  w_in_range && !w_key_hit &&  w_full;
    assign w_push = iPlot &&  w_in_range && !w_key_hit && !w_full;
    assign w_pop  = !w_empty && iMemReady;

    // The range check bounds the result to X*Y-1, so no clipping is needed.
    assign w_addr = ADDR_WIDTH'(iY) * ADDR_WIDTH'(X_SCREEN_PIXELS) + ADDR_WIDTH'(iX);

    // ------------------------------------------------------------------
    // Storage array (no reset: contents are qualified by r_count)
    // ------------------------------------------------------------------
    always_ff @(posedge iClock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {w_addr, iColour};
        end
    end

    // ------------------------------------------------------------------
    // Pointers, occupancy and status
    // ------------------------------------------------------------------
    always_ff @(posedge iClock) begin
        if (!iResetn) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_overflow   <= 1'b0;
            r_drop_count <= 8'd0;
        end else begin
            // Pointer width equals log2(depth), so increments wrap naturally.
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_count_one;
                2'b01:   r_count <= r_count - c_count_one;
                default: r_count <= r_count;
            endcase

            if (w_lost) begin
                r_overflow <= 1'b1;
            end

            if (w_drop && (r_drop_count != c_drop_max)) begin
                r_drop_count <= r_drop_count + 8'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Memory port. Held low while reset is asserted so the port never sees
    // a write on a cycle whose pop is being discarded.
    // ------------------------------------------------------------------
    logic               w_valid;
    logic [ENTRY_W-1:0] w_head;

    assign w_valid = !w_empty && iResetn;
    assign w_head  = r_mem[r_rd_ptr];

    assign oMemWrEn   = w_valid;
    assign oMemAddr   = w_valid ? w_head[ENTRY_W-1:3] : '0;
    assign oMemData   = w_valid ? w_head[2:0]         : 3'd0;
    assign oFull      = w_full;
    assign oIdle      = w_empty;
    assign oOverflow  = r_overflow;
    assign oDropCount = r_drop_count;

endmodule

`default_nettype wire

// File: tb/tb_pixel_fb_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pixel_fb_writer
// Purpose  : Directed bench for pixel_fb_writer. Stimulus pushes the expected
//            {address, colour} of every accepted pixel into a scoreboard
//            queue; an independent monitor pops and compares on every
//            completed memory write.
// Revision : 1.0 - initial release
// ============================================================================

module tb_pixel_fb_writer;

    logic        clk;
    logic        iResetn;
    logic [7:0]  iX;
    logic [6:0]  iY;
    logic [2:0]  iColour;
    logic        iPlot;
    logic        iMemReady;
    logic [14:0] oMemAddr;
    logic [2:0]  oMemData;
    logic        oMemWrEn;
    logic        oFull;
    logic        oIdle;
    logic        oOverflow;
    logic [7:0]  oDropCount;

    int checks = 0;
    int errors = 0;

    logic [17:0] sb_q[$];

    pixel_fb_writer dut (
        .iClock     (clk),
        .iResetn    (iResetn),
        .iX         (iX),
        .iY         (iY),
        .iColour    (iColour),
        .iPlot      (iPlot),
        .iMemReady  (iMemReady),
        .oMemAddr   (oMemAddr),
        .oMemData   (oMemData),
        .oMemWrEn   (oMemWrEn),
        .oFull      (oFull),
        .oIdle      (oIdle),
        .oOverflow  (oOverflow),
        .oDropCount (oDropCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one pixel for one edge; expected entry queued only if accepted.
    task automatic plot(input int x, input int y, input int c, input bit accept, input int exp_addr);
        iX      = 8'(x);
        iY      = 7'(y);
        iColour = 3'(c);
        iPlot   = 1'b1;
        if (accept) sb_q.push_back({15'(exp_addr), 3'(c)});
        tick();
        iPlot = 1'b0;
    endtask

    // Monitor: compares the head against the scoreboard on every cycle.
    always @(negedge clk) begin
        if (iResetn) begin
            if (oMemWrEn) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write actual_addr=%0d required=none", oMemAddr);
                end else begin
                    check("write_entry", {14'd0, oMemAddr, oMemData}, {14'd0, sb_q[0]});
                    if (iMemReady) void'(sb_q.pop_front());
                end
            end else begin
                check("empty_outputs_zero", {14'd0, oMemAddr, oMemData}, 32'd0);
            end
        end
    end

    logic key_on;

    initial begin
`ifdef PIXEL_FB_COLOUR_KEY_EN
        key_on = 1'b1;
`else
        key_on = 1'b0;
`endif
        iResetn = 1'b0; iX = '0; iY = '0; iColour = '0; iPlot = 1'b0; iMemReady = 1'b0;
        tick(); tick();

        // Reset state
        check("rst_wren",     oMemWrEn,   0);
        check("rst_addr",     oMemAddr,   0);
        check("rst_data",     oMemData,   0);
        check("rst_full",     oFull,      0);
        check("rst_idle",     oIdle,      1);
        check("rst_overflow", oOverflow,  0);
        check("rst_drop",     oDropCount, 0);
        iResetn = 1'b1;
        tick();

        // 1: single pixel, one-cycle latency
        iMemReady = 1'b1;
        plot(5, 3, 4, 1'b1, 485);
        check("t1_wren", oMemWrEn, 1);
        check("t1_addr", oMemAddr, 485);
        check("t1_data", oMemData, 4);
        tick();
        check("t1_idle", oIdle, 1);

        // 2: fill while stalled, two pixels lost, then burst drain
        iMemReady = 1'b0;
        for (int i = 0; i < 10; i++) plot(i, 1, (i % 7) + 1, (i < 8), 160 + i);
        check("t2_full",     oFull,     1);
        check("t2_overflow", oOverflow, 1);
        check("t2_not_idle", oIdle,     0);
        iMemReady = 1'b1;
        for (int k = 0; k < 8; k++) begin
            check("t2_burst_wren", oMemWrEn, 1);
            tick();
        end
        check("t2_drained", oIdle, 1);

        // 3: range boundaries
        plot(160, 0,   3, 1'b0, 0);
        plot(0,   120, 3, 1'b0, 0);
        check("t3_drop2", oDropCount, 2);
        check("t3_idle",  oIdle,      1);
        plot(159, 119, 5, 1'b1, 19199);
        check("t3_max_addr", oMemAddr, 19199);
        tick();
        // Drop counter saturation
        for (int i = 0; i < 260; i++) plot(200, 0, 1, 1'b0, 0);
        check("t3_drop_sat", oDropCount, 255);

        // 4: steady state at occupancy 4 with push and pop every cycle
        iMemReady = 1'b0;
        for (int i = 0; i < 4; i++) plot(i, 2, 6, 1'b1, 320 + i);
        iMemReady = 1'b1;
        for (int i = 4; i < 24; i++) begin
            check("t4_not_full", oFull, 0);
            check("t4_not_idle", oIdle, 0);
            plot(i, 2, (i % 7) + 1, 1'b1, 320 + i);
        end
        for (int k = 0; k < 4; k++) begin
            check("t4_tail_wren", oMemWrEn, 1);
            tick();
        end
        check("t4_idle", oIdle, 1);

        // 5: reset with entries queued
        iMemReady = 1'b0;
        for (int i = 0; i < 5; i++) plot(i, 4, 2, 1'b1, 640 + i);
        iResetn = 1'b0;
        sb_q.delete();
        tick();
        check("t5_wren",     oMemWrEn,   0);
        check("t5_idle",     oIdle,      1);
        check("t5_drop",     oDropCount, 0);
        check("t5_overflow", oOverflow,  0);
        iResetn = 1'b1;
        tick();

        // 6: colour keying
        iMemReady = 1'b1;
        plot(10, 5, 0, !key_on, 810);
        plot(11, 5, 2, 1'b1,    811);
        plot(12, 5, 0, !key_on, 812);
        plot(13, 5, 7, 1'b1,    813);
        tick(); tick(); tick();
        check("t6_idle",     oIdle,      1);
        check("t6_drop",     oDropCount, 0);
        check("t6_overflow", oOverflow,  0);

        // Every expected write must have been seen
        for (int k = 0; k < 50 && sb_q.size() != 0; k++) tick();
        check("sb_empty", sb_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
